// File: rtl/bram_a_port_arbiter.sv
// Shares BRAM A port 0 between the operand reader and the write-back stream.
// Reads always own the port; write-back rows wait in a small FIFO and drain
// into cycles where the reader is idle. Write addresses are generated from the
// latched output base, and completion is reported once every expected row has
// been either committed to the BRAM or dropped on overflow.
module bram_a_port_arbiter #(
  parameter int AWIDTH       = 10,
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4,
  parameter int MASK_WIDTH   = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int CWIDTH       = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_start,
  input  logic [AWIDTH-1:0]                   i_base_addr,
  input  logic [CWIDTH-1:0]                   i_expected_rows,
  input  logic                                i_rd_en,
  input  logic [AWIDTH-1:0]                   i_rd_addr,
  input  logic                                i_wr_valid,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0]      i_wr_data,
  output logic [AWIDTH-1:0]                   o_bram_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0]      o_bram_wdata,
  output logic [MASK_WIDTH-1:0]               o_bram_we,
  output logic [$clog2(FIFO_DEPTH):0]         o_fifo_count,
  output logic                                o_wr_overflow,
  output logic                                o_wr_done
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNTW  = PW + 1;
  localparam int DATAW = MAT_MUL_SIZE * DWIDTH;

  // FIFO storage; pointers carry one extra wrap bit so full/empty are distinct
  logic [AWIDTH-1:0] r_addr_mem [FIFO_DEPTH];
  logic [DATAW-1:0]  r_data_mem [FIFO_DEPTH];
  logic [CNTW-1:0]   r_wptr, r_rptr;

  logic [AWIDTH-1:0] r_base;
  logic [CWIDTH-1:0] r_expected;
  logic [CWIDTH-1:0] r_push_cnt, r_commit_cnt, r_drop_cnt;
  logic              r_seen_start;
  logic              r_overflow;
  logic              r_done;

  logic [CNTW-1:0]   w_count;
  logic              w_empty, w_full;
  logic              w_pop, w_push, w_drop;
  logic [AWIDTH-1:0] w_base;
  logic [CWIDTH-1:0] w_pcnt;
  logic [AWIDTH-1:0] w_push_addr;
  logic [PW-1:0]     w_widx;
  logic [CNTW-1:0]   w_wptr_n, w_rptr_n;
  logic [CWIDTH-1:0] w_commit_n, w_drop_n, w_expected_n;
  logic [CWIDTH:0]   w_sum_n;
  logic              w_seen_n, w_done_n, w_overflow_n;

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == CNTW'(FIFO_DEPTH));

  // A start flushes the queue, so nothing may leave it in that cycle.
  assign w_pop  = !i_rd_en && !w_empty && !i_start;
  // After a flush there is always room; otherwise a pop frees the slot in time.
  assign w_push = i_wr_valid && (i_start || !w_full || w_pop);
  assign w_drop = i_wr_valid && !w_push;

  // A row arriving with start uses the new base at row index zero.
  assign w_base      = i_start ? i_base_addr : r_base;
  assign w_pcnt      = i_start ? '0 : r_push_cnt;
  assign w_push_addr = w_base + AWIDTH'(w_pcnt * MAT_MUL_SIZE);
  assign w_widx      = i_start ? '0 : r_wptr[PW-1:0];

  // Next-state view of the queue and counters, used to register wr_done so it
  // reflects the state right after this edge.
  always_comb begin
    w_wptr_n     = (i_start ? '0 : r_wptr) + CNTW'(w_push);
    w_rptr_n     = (i_start ? '0 : r_rptr) + CNTW'(w_pop);
    w_commit_n   = (i_start ? '0 : r_commit_cnt) + CWIDTH'(w_pop);
    w_drop_n     = (i_start ? '0 : r_drop_cnt) + CWIDTH'(w_drop);
    w_expected_n = i_start ? i_expected_rows : r_expected;
    w_seen_n     = r_seen_start || i_start;
    w_sum_n      = {1'b0, w_commit_n} + {1'b0, w_drop_n};
    w_overflow_n = (r_overflow && !i_start) || w_drop;
    w_done_n     = (r_done && !i_start) ||
                   (w_seen_n && (w_sum_n == {1'b0, w_expected_n}) && (w_wptr_n == w_rptr_n));
  end

  // Port mux: reader has priority; a buffered row drains only on idle cycles.
  always_comb begin
    o_bram_addr  = i_rd_addr;
    o_bram_wdata = '0;
    o_bram_we    = '0;
    if (w_pop) begin
      o_bram_addr  = r_addr_mem[r_rptr[PW-1:0]];
      o_bram_wdata = r_data_mem[r_rptr[PW-1:0]];
      o_bram_we    = '1;
    end
  end

  // FIFO payload write; contents need no reset since pointers gate all reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[w_widx] <= w_push_addr;
      r_data_mem[w_widx] <= i_wr_data;
    end
  end

  // Control state: pointers, counters, latched job parameters and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_base       <= '0;
      r_expected   <= '0;
      r_push_cnt   <= '0;
      r_commit_cnt <= '0;
      r_drop_cnt   <= '0;
      r_seen_start <= 1'b0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_wptr       <= w_wptr_n;
      r_rptr       <= w_rptr_n;
      r_base       <= w_base;
      r_expected   <= w_expected_n;
      // Counts every offered row, dropped or not, so later addresses stay right.
      r_push_cnt   <= w_pcnt + CWIDTH'(i_wr_valid);
      r_commit_cnt <= w_commit_n;
      r_drop_cnt   <= w_drop_n;
      r_seen_start <= w_seen_n;
      r_overflow   <= w_overflow_n;
      r_done       <= w_done_n;
    end
  end

  assign o_fifo_count  = w_count;
  assign o_wr_overflow = r_overflow;
  assign o_wr_done     = r_done;

endmodule
